// File: rtl/regfile_2r1w_if.sv
// regfile_2r1w_if: write port plus two read ports of the 2R1W register file.
interface regfile_2r1w_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_a_en;
  logic [ADDR_WIDTH-1:0] rd_a_addr;
  logic [DATA_WIDTH-1:0] rd_a_data;
  logic                  rd_a_valid;
  logic                  rd_b_en;
  logic [ADDR_WIDTH-1:0] rd_b_addr;
  logic [DATA_WIDTH-1:0] rd_b_data;
  logic                  rd_b_valid;
  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    input  rd_a_data, rd_a_valid, rd_b_data, rd_b_valid
  );
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    output rd_a_data, rd_a_valid, rd_b_data, rd_b_valid
  );
endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_WIDTH register file, one write port, two registered
// write-first read ports, optional hard-wired zero register 0.
module regfile_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 0
) (
  input logic clk,
  input logic reset,
  regfile_2r1w_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_a_data, r_b_data;
  logic                  r_a_valid, r_b_valid;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_a_next, w_b_next;
  // Writes to register 0 are dropped when it is hard-wired to zero.
  assign w_wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
  // Read value as it stands after this edge's write: forward the write on a hit.
  always_comb begin
    w_a_next = ((ZERO_REG != 0) && (bus.rd_a_addr == '0)) ? '0 :
               (w_wr_ok && (bus.wr_addr == bus.rd_a_addr)) ? bus.wr_data :
               r_mem[bus.rd_a_addr];
    w_b_next = ((ZERO_REG != 0) && (bus.rd_b_addr == '0)) ? '0 :
               (w_wr_ok && (bus.wr_addr == bus.rd_b_addr)) ? bus.wr_data :
               r_mem[bus.rd_b_addr];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
    end else begin
      r_a_valid <= bus.rd_a_en;
      r_b_valid <= bus.rd_b_en;
      if (bus.rd_a_en) r_a_data <= w_a_next;
      if (bus.rd_b_en) r_b_data <= w_b_next;
    end
  end
  assign bus.rd_a_data  = r_a_data;
  assign bus.rd_a_valid = r_a_valid;
  assign bus.rd_b_data  = r_b_data;
  assign bus.rd_b_valid = r_b_valid;
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file with one synchronous write port and two registered read ports; each read port selects one of DEPTH registers and returns its contents one cycle later. It sits between instruction decode and the ALU, supplying the Rsrc/Rdest operand pair. Same-cycle write-to-read forwarding is built in, and register 0 can optionally be hard-wired to zero.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per register and per data port
- ADDR_WIDTH, 4, register index width; DEPTH = 2**ADDR_WIDTH
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-high; clears all state
- wr_en  input  1  write strobe, sampled on the rising edge of clk
- wr_addr  input  ADDR_WIDTH  write register index
- wr_data  input  DATA_WIDTH  write value
- rd_a_en  input  1  read request, port A
- rd_a_addr  input  ADDR_WIDTH  port A register index
- rd_a_data  output  DATA_WIDTH  port A registered read data
- rd_a_valid  output  1  high for the one cycle after an accepted port A read
- rd_b_en, rd_b_addr, rd_b_data, rd_b_valid: same as port A, for port B

## Operation
- Storage is an array of DEPTH registers, each DATA_WIDTH bits.
- Write: on each rising edge of clk with wr_en=1, mem[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read, each port independently: on a rising edge with rd_x_en=1:
  - rd_x_data <= value of mem[rd_x_addr] as it stands after that edge's write (write-first).
  - rd_x_valid <= 1.
- Forwarding: if wr_en=1 and wr_addr==rd_x_addr on the same edge, rd_x_data takes wr_data, not the old contents.
  - Exception: with ZERO_REG=1 and the address equal to 0, rd_x_data takes 0.
- With ZERO_REG=1, any read of register 0 returns 0, whether or not forwarding applies.
- rd_x_en=0: rd_x_data holds its previous value; rd_x_valid <= 0.
- Both ports may read the same address in the same cycle. Both return identical data, including the forwarded value.
- There are no illegal address values, because all 2**ADDR_WIDTH indices exist. There is no default or out-of-range path.
- No state machine beyond the storage array and the two output stages.

## Timing
- Reset asserted, asynchronously and without waiting for clk:
  - every mem entry = 0
  - rd_a_data = rd_b_data = 0
  - rd_a_valid = rd_b_valid = 0
- While reset is high, writes and reads are ignored.
- Release: the first rising edge with reset low is the first active edge.
- Reset asserted mid-operation: any read result due on the next edge is lost; valid stays 0.
- Write latency: the value is visible to a read issued on the same edge, through forwarding.
- Read latency: exactly 1 cycle from the edge sampling rd_x_en=1 to data and valid being present. Back-to-back reads are sustained at 1 per cycle per port.
- Outputs are driven directly by flops, with no combinational path from inputs to outputs.

## Test plan
- Reset: write 16'hBEEF to r5, then pulse reset asynchronously between edges.
  - rd_a_data, rd_b_data and both valid signals drop to 0 immediately.
  - A subsequent read of r5 returns 16'h0000.
- Basic write/read: write r3=16'h1234 and r12=16'hA5A5, then read A=r3 and B=r12 on one edge.
  - One cycle later: rd_a_data=16'h1234, rd_b_data=16'hA5A5, both valid=1.
  - One cycle after that, with rd_en low: both valid=0 and data holds.
- Forwarding: r7=16'h0001; on the same edge, write r7=16'h00FF and read A=r7, B=r7.
  - Both ports return 16'h00FF.
- ZERO_REG=1: write r0=16'hFFFF, read r0 on both ports, including the same-edge bypass case.
  - Both ports return 16'h0000.
- ZERO_REG=0 counterpart: the same sequence returns 16'hFFFF.
- Sweep: write mem[i]=i*16'h1111 for i=0..15, then read A=i and B=15-i for 16 consecutive cycles.
  - Every result matches, valid is high on each of the 16 cycles, and there are no bubbles.
- Parametrisation: instantiate DATA_WIDTH=32, ADDR_WIDTH=5.
  - Write r31=32'hDEADBEEF and read it back as 32'hDEADBEEF.
  - r0..r30 are untouched and remain 0.
